sram_like_responder: RTL and testbench

//   Slave/responder end of the SRAM-like req/addr_ok/data_ok bus that the CPU core drives on its inst and data ports.

---
 rtl/sram_like_responder.sv | 118 +++++++++++
 tb/tb_sram_like_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// In-order SRAM-like bus responder backed by a word memory, with a fixed response latency.
// Define SRAM_LIKE_RAND_STALL_EN to add LFSR-driven addr_ok bubbles and extra latency.
module sram_like_responder #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_LAT        = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(MAX_OUTSTANDING - 1);

  logic [31:0]       mem        [Depth];
  logic [31:0]       ent_data_q [MAX_OUTSTANDING];
  logic [4:0]        ent_cnt_q  [MAX_OUTSTANDING];
  ptr_t              head_q, tail_q;
  logic [2:0]        count_q;
  logic              live_q;
  logic              stall;
  logic [4:0]        extra;
  logic              accept;
  logic              retire;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  assign idx         = addr[ADDR_W+1:2];
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = lfsr_q[0] & lfsr_q[3];
  assign extra = {3'b000, lfsr_q[5:4]};
`else
  assign stall = 1'b0;
  assign extra = 5'd0;
`endif

  function automatic ptr_t inc_ptr(input ptr_t p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // live_q keeps addr_ok low until the first edge after reset is released
  assign addr_ok = live_q & (count_q < 3'(MAX_OUTSTANDING)) & ~stall;
  assign accept  = req & addr_ok;
  // Countdown holds remaining cycles minus one so the head can fire in the cycle it hits zero
  assign retire  = (count_q != 3'd0) & (ent_cnt_q[head_q] == 5'd0);
  assign data_ok = retire;
  assign rdata   = retire ? ent_data_q[head_q] : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 3'd0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        ent_data_q[i] <= 32'h0;
        ent_cnt_q[i]  <= 5'd0;
      end
    end else begin
      live_q <= 1'b1;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (ent_cnt_q[i] != 5'd0) begin
          ent_cnt_q[i] <= ent_cnt_q[i] - 5'd1;
        end
      end
      if (accept) begin
        ent_cnt_q[tail_q]  <= 5'(DATA_LAT - 1) + extra;
        ent_data_q[tail_q] <= wr ? 32'h0 : mem[idx];
        tail_q             <= inc_ptr(tail_q);
      end
      if (retire) begin
        head_q <= inc_ptr(head_q);
      end
      if (accept && !retire) begin
        count_q <= count_q + 3'd1;
      end else if (retire && !accept) begin
        count_q <= count_q - 3'd1;
      end
    end
  end

  // Writes commit at accept, so a later read of the same word sees the new data
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Self-checking bench for sram_like_responder: directed vectors, a full-queue sequence,
// an async reset check and randomized traffic against a queue-based response model.
module tb_sram_like_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned MO = 2;
  localparam int unsigned DL = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_like_responder #(
    .ADDR_W         (AW),
    .MAX_OUTSTANDING(MO),
    .DATA_LAT       (DL)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .wr     (wr),
    .size   (size),
    .wstrb  (wstrb),
    .addr   (addr),
    .wdata  (wdata),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .rdata  (rdata)
  );

  // Reference model: word memory plus FIFO of pending responses with their earliest cycle
  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  logic [31:0] mmem [1024];
  resp_t       q[$];
  int          now = 0;
  bit          live = 1'b0;

  typedef struct {
    bit          w;
    logic [3:0]  strb;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples and checks one cycle at the negedge, updates the model, then crosses the posedge
  task automatic step(output bit acc, output bit dok, output logic [31:0] rd);
    bit ea;
    bit ed;
    int i;
    @(negedge clk);
    ea  = live && (q.size() < int'(MO));
    ed  = (q.size() > 0) && (now >= q[0].due);
    acc = req && addr_ok;
    dok = data_ok;
    rd  = rdata;
    check("addr_ok", 32'(addr_ok), 32'(ea));
    check("data_ok", 32'(data_ok), 32'(ed));
    if (ed) begin
      check("rdata", rdata, q[0].data);
      void'(q.pop_front());
    end
    if (req && ea) begin
      i = int'(addr[AW+1:2]);
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mmem[i][8*b +: 8] = wdata[8*b +: 8];
        end
        q.push_back('{data: 32'h0, due: now + int'(DL)});
      end else begin
        q.push_back('{data: mmem[i], due: now + int'(DL)});
      end
    end
    @(posedge clk);
    #1;
    now++;
    live = 1'b1;
  endtask

  task automatic issue(input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd_out);
    bit acc;
    bit dok;
    logic [31:0] rd;
    int k;
    req = 1'b1; wr = w; wstrb = s; addr = a; wdata = d;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 20) begin
      step(acc, dok, rd);
      k++;
    end
    req = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no accept expected accept within 20 cycles");
    end
    lat = -1;
    rd_out = 32'h0;
    k = 0;
    while (lat < 0 && k < 20) begin
      step(acc, dok, rd);
      k++;
      if (dok) begin
        lat = k;
        rd_out = rd;
      end
    end
  endtask

  initial begin
    bit          acc;
    bit          dok;
    logic [31:0] rd;
    int          lat;
    int          start;
    int          cur;
    int          acc_n;
    int          idx;
    int          acc_cyc[$];
    int          dok_cyc[$];
    logic [31:0] dok_dat[$];
    vec_t        vecs[8];
    logic [31:0] seq_addr[4];
    int          exp_acc[4];
    int          exp_dok[4];
    logic [31:0] exp_dat[4];

    vecs[0] = '{1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         32'h1234_5678};
    vecs[2] = '{1'b1, 4'h4, 32'h0000_0042, 32'h00AB_0000, 32'h0};
    vecs[3] = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         32'h12AB_5678};
    vecs[4] = '{1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0};
    vecs[5] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 4'hF, 32'h0000_0044, 32'hFFFF_FFFF, 32'h0};
    vecs[7] = '{1'b1, 4'h9, 32'h0000_0044, 32'h1155_6622, 32'h0};

    // Reset asserted from time zero
    #1;
    check("rst_addr_ok", 32'(addr_ok), 32'h0);
    check("rst_data_ok", 32'(data_ok), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    now = 0;
    live = 1'b0;
    step(acc, dok, rd);

    // Two writes pending, then async reset in the cycle the first would retire
    req = 1'b1; wr = 1'b1; wstrb = 4'hF;
    addr = 32'h80; wdata = 32'hA5A5_0001;
    step(acc, dok, rd);
    addr = 32'h84; wdata = 32'hA5A5_0002;
    step(acc, dok, rd);
    req = 1'b0;
    step(acc, dok, rd);
    check("pre_rst_data_ok", 32'(data_ok), 32'h1);
    resetn = 1'b0;
    #1;
    check("async_addr_ok", 32'(addr_ok), 32'h0);
    check("async_data_ok", 32'(data_ok), 32'h0);
    check("async_rdata", rdata, 32'h0);
    q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    now = 0;
    live = 1'b0;
    repeat (8) step(acc, dok, rd);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].w, vecs[i].strb, vecs[i].a, vecs[i].d, lat, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(DL));
    end

    // Held req for four reads against a two-deep queue
    seq_addr = '{32'h40, 32'h0, 32'h44, 32'h40};
    exp_acc  = '{0, 1, 4, 5};
    exp_dok  = '{3, 4, 7, 8};
    exp_dat  = '{32'h12AB_5678, 32'hDEAD_BEEF, 32'h11FF_FF22, 32'h12AB_5678};
    start = now;
    acc_n = 0;
    req = 1'b1; wr = 1'b0;
    for (int k = 0; k < 30 && dok_cyc.size() < 4; k++) begin
      addr = seq_addr[acc_n];
      cur = now;
      step(acc, dok, rd);
      if (acc) begin
        acc_cyc.push_back(cur - start);
        acc_n++;
        if (acc_n == 4) req = 1'b0;
      end
      if (dok) begin
        dok_cyc.push_back(cur - start);
        dok_dat.push_back(rd);
      end
    end
    req = 1'b0;
    check("seq_accepts", 32'(acc_cyc.size()), 32'd4);
    check("seq_responses", 32'(dok_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) check($sformatf("seq_acc%0d", i), 32'(acc_cyc[i]), 32'(exp_acc[i]));
      if (i < dok_cyc.size()) begin
        check($sformatf("seq_dok%0d", i), 32'(dok_cyc[i]), 32'(exp_dok[i]));
        check($sformatf("seq_dat%0d", i), dok_dat[i], exp_dat[i]);
      end
    end

    // Randomized traffic over 16 pre-written words with junk in the ignored address bits
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 4'hF, 32'h100 + 32'(i * 4), $urandom, lat, rd);
    end
    for (int i = 0; i < 600; i++) begin
      idx   = $urandom_range(0, 15);
      req   = ($urandom_range(0, 9) < 7);
      wr    = 1'($urandom_range(0, 1));
      wstrb = 4'($urandom);
      wdata = $urandom;
      addr  = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'(idx << 2) | 32'($urandom_range(0, 3));
      step(acc, dok, rd);
    end
    req = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      step(acc, dok, rd);
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    repeat (4) step(acc, dok, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
